// File: rtl/issue_queue_ctrl.sv
// Dual-issue instruction queue controller.
// Fetched pc/instruction pairs are pushed into a circular buffer. The two
// oldest entries are presented to decode, and the issue decision comes back
// combinationally. It takes account of RAW hazards, shared units, and branch
// delay slots.
// Optional feature: define DUAL_ISSUE_EN to allow two issues per cycle.
// Without it, at most one entry issues per cycle, and a branch at the head
// always waits for its delay slot.
// Ports:
//   cpu_clk_50M, cpu_rst        clock, asynchronous active-high reset
//   flush, stall                discard queue / hold issue
//   push_valid, push_pc*/inst*  up to two fetched entries, older in slot 0
//   push_ready                  at least two entries free
//   inst1_*/inst2_* pc/inst     head and head+1 entries, zero when absent
//   inst1_*/inst2_* decode      decode of the presented entries
//   issue_valid, inst*_is_ds    issue decision and delay-slot marks
//   count                       occupied entries
module issue_queue_ctrl #(
   parameter int unsigned QDEPTH = 8
) (
   input  logic                      cpu_clk_50M,
   input  logic                      cpu_rst,
   input  logic                      flush,
   input  logic                      stall,
   input  logic [1:0]                push_valid,
   input  logic [31:0]               push_pc0,
   input  logic [31:0]               push_inst0,
   input  logic [31:0]               push_pc1,
   input  logic [31:0]               push_inst1,
   output logic                      push_ready,
   output logic [31:0]               inst1_pc,
   output logic [31:0]               inst1_inst,
   output logic [31:0]               inst2_pc,
   output logic [31:0]               inst2_inst,
   input  logic                      inst1_wreg,
   input  logic [4:0]                inst1_wa,
   input  logic                      inst1_mult_div,
   input  logic                      inst1_load_store,
   input  logic                      inst1_jmp_branch,
   input  logic                      inst2_rreg1,
   input  logic                      inst2_rreg2,
   input  logic [4:0]                inst2_rs,
   input  logic [4:0]                inst2_rt,
   input  logic                      inst2_mult_div,
   input  logic                      inst2_load_store,
   input  logic                      inst2_jmp_branch,
   output logic [1:0]                issue_valid,
   output logic                      inst1_is_ds,
   output logic                      inst2_is_ds,
   output logic [$clog2(QDEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

`ifdef DUAL_ISSUE_EN
   localparam bit DUAL_EN = 1'b1;
`else
   localparam bit DUAL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   typedef enum logic {NORMAL, DS_WAIT} state_t;

   entry_t              mem [QDEPTH];
   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic [PTR_W-1:0]    head_p1;
   state_t              state;
   state_t              state_nxt;
   logic                push_ok;
   logic [CNT_W-1:0]    push_n;
   logic [CNT_W-1:0]    pop_n;
   logic                raw_hazard;
   logic                dual_ok;

   // Push accepted only with two free entries; slot1 without slot0 is ignored.
   assign push_ready = (count <= CNT_W'(QDEPTH - 2));
   assign push_ok    = push_ready && push_valid[0] && !flush;
   assign push_n     = push_ok ? (push_valid[1] ? CNT_W'(2) : CNT_W'(1)) : CNT_W'(0);
   assign pop_n      = CNT_W'(issue_valid[0]) + CNT_W'(issue_valid[1]);

   // Head and head+1 presented to decode, zeroed when absent.
   assign head_p1    = head + PTR_W'(1);
   assign inst1_pc   = (count != CNT_W'(0)) ? mem[head].pc     : 32'h0;
   assign inst1_inst = (count != CNT_W'(0)) ? mem[head].inst   : 32'h0;
   assign inst2_pc   = (count >= CNT_W'(2)) ? mem[head_p1].pc   : 32'h0;
   assign inst2_inst = (count >= CNT_W'(2)) ? mem[head_p1].inst : 32'h0;

   // inst2 reads a register that inst1 writes (r0 never carries a dependency).
   assign raw_hazard = inst1_wreg && (inst1_wa != 5'd0) &&
                       ((inst2_rreg1 && (inst1_wa == inst2_rs)) ||
                        (inst2_rreg2 && (inst1_wa == inst2_rt)));

   assign dual_ok = DUAL_EN && (state == NORMAL) && (count >= CNT_W'(2)) &&
                    !raw_hazard &&
                    !(inst1_mult_div && inst2_mult_div) &&
                    !(inst1_load_store && inst2_load_store) &&
                    !inst2_jmp_branch;

   // Issue decision and delay-slot tracking.
   always_comb begin : issue_logic
      issue_valid = 2'b00;
      inst1_is_ds = 1'b0;
      inst2_is_ds = 1'b0;
      state_nxt   = state;
      if (!stall && !flush && (count != CNT_W'(0))) begin
         if (state == DS_WAIT) begin
            issue_valid = 2'b01;
            inst1_is_ds = 1'b1;
            state_nxt   = NORMAL;
         end else if (inst1_jmp_branch) begin
            if (dual_ok) begin
               issue_valid = 2'b11;
               inst2_is_ds = 1'b1;
            end else begin
               // Branch leaves alone; its delay slot is owed on a later cycle.
               issue_valid = 2'b01;
               state_nxt   = DS_WAIT;
            end
         end else begin
            issue_valid = dual_ok ? 2'b11 : 2'b01;
         end
      end
   end

   // Pointers, occupancy and FSM state.
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin : ctrl_regs
      if (cpu_rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= NORMAL;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= NORMAL;
      end else begin
         head  <= head + PTR_W'(pop_n);
         tail  <= tail + PTR_W'(push_n);
         count <= count + push_n - pop_n;
         state <= state_nxt;
      end
   end

   // Entry storage; contents are only visible through count, so no reset.
   always_ff @(posedge cpu_clk_50M) begin : entry_store
      if (push_ok) begin
         mem[tail] <= {push_pc0, push_inst0};
         if (push_valid[1]) begin
            mem[tail + PTR_W'(1)] <= {push_pc1, push_inst1};
         end
      end
   end

endmodule

// File: doc/issue_queue_ctrl.md
ISSUE_QUEUE_CTRL -- requirements
Module: issue_queue_ctrl

Interface
REQ-001 SHALL have parameter QDEPTH, default 8, queue entries (power of two, >=4).
REQ-002 SHALL have ports in this order: cpu_clk_50M  in  1  sole clock, rising edge.
REQ-003 cpu_rst  in  1  asynchronous, active-high reset.
REQ-004 flush  in  1  discard all queued entries (exception/redirect).
REQ-005 stall  in  1  downstream stall; no entry issues this cycle.
REQ-006 push_valid  in  2  bit0 = first fetched slot valid, bit1 = second; bit1 without bit0 is illegal.
REQ-007 push_pc0/push_inst0, push_pc1/push_inst1  in  32 each  fetched pairs, older in slot 0.
REQ-008 push_ready  out  1  high when at least 2 entries are free.
REQ-009 inst1_pc, inst1_inst, inst2_pc, inst2_inst  out  32 each  queue head and head+1, zero when that entry is absent.
REQ-010 inst1_wreg, inst1_wa[4:0], inst1_mult_div, inst1_load_store, inst1_jmp_branch  in  decode of inst1 (same cycle).
REQ-011 inst2_rreg1, inst2_rreg2, inst2_rs[4:0], inst2_rt[4:0], inst2_mult_div, inst2_load_store, inst2_jmp_branch  in  decode of inst2.
REQ-012 issue_valid  out  2  bit0 = inst1 issues, bit1 = inst2 issues.
REQ-013 inst1_is_ds, inst2_is_ds  out  1 each  issued instruction is a branch delay slot.
REQ-014 count  out  log2(QDEPTH)+1  occupied entries.

Function
REQ-015 Queue SHALL be a circular buffer with head/tail pointers wrapping modulo QDEPTH.
REQ-016 Push SHALL write only when push_ready; pushes while push_ready=0 are dropped; 1 or 2 entries per cycle per push_valid.
REQ-017 Pop SHALL remove popcount(issue_valid) entries at the clock edge; push and pop in the same cycle SHALL both take effect; count updates as count+pushed-popped.
REQ-018 issue_valid SHALL be combinational from current state and decode inputs; 00 when stall=1, flush=1, or count=0.
REQ-019 inst2 dual issue SHALL be inhibited when: count<2; inst1_wreg and inst1_wa!=0 and inst1_wa matches inst2_rs (rreg1) or inst2_rt (rreg2); both mult_div; both load_store; inst2_jmp_branch=1; FSM in DS_WAIT.
REQ-020 FSM states SHALL be NORMAL and DS_WAIT.
REQ-021 NORMAL, inst1 not branch: issue inst1, plus inst2 unless inhibited.
REQ-022 NORMAL, inst1 branch, inst2 not inhibited: issue both, inst2_is_ds=1, stay NORMAL.
REQ-023 NORMAL, inst1 branch, inst2 inhibited (incl. count=1): issue branch alone, go to DS_WAIT.
REQ-024 DS_WAIT: when count>=1 and not stalled, issue inst1 alone with inst1_is_ds=1, return to NORMAL; otherwise hold DS_WAIT.
REQ-025 flush SHALL, at the edge, zero pointers and count, drop same-cycle pushes, force NORMAL; flush has priority over push, pop and stall.
REQ-026 *_is_ds SHALL be 0 whenever the corresponding issue_valid bit is 0.

Reset
REQ-027 cpu_rst SHALL asynchronously set head=tail=count=0, FSM=NORMAL; thus push_ready=1, issue_valid=00, *_is_ds=0, instruction/pc outputs zero.
REQ-028 Reset mid-operation SHALL discard all entries, including an owed delay slot.

Configuration
REQ-029 Macro DUAL_ISSUE_EN defined: behaviour as above.
REQ-030 Macro DUAL_ISSUE_EN undefined: issue_valid[1] SHALL be constant 0; branch at head always takes REQ-023 path; queue depth and push width unchanged.

Verification
REQ-031 Reset, then push 2 independent ALU instrs (pc 0xBFC00000/04) -> next cycle issue_valid=11, count returns 0.
REQ-032 inst1 addu $3 writes wa=3, inst2 reads rs=3 -> issue_valid=01, inst2 issues alone the following cycle.
REQ-033 inst1 beq, count=1 -> branch issues alone, DS_WAIT; push delay slot -> issue_valid=01, inst1_is_ds=1, FSM NORMAL.
REQ-034 Fill to count=QDEPTH-1 -> push_ready=0; push dropped; simultaneous 2-pop + 2-push at count=6 keeps count=6 with pointers wrapping correctly.
REQ-035 flush asserted with count=5 and push_valid=11 -> next cycle count=0, issue_valid=00, FSM NORMAL.
REQ-036 Build without DUAL_ISSUE_EN, 4 independent instrs queued -> one issue per cycle over 4 cycles.
